// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, the word
// returned to a requester whose access is aborted, and the default busy limit.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_D  = 2'b10,
        RESP    = 2'b11
    } arb_state_e;

    localparam logic [31:0] ABORT_DATA             = 32'hDEADBEEF;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arbiter_bus_timer.sv
// bus_timer: 16-bit busy-cycle counter for the memory arbiter.
// clear restarts the count, enable advances it by one per cycle, and expired
// is high during the cycle in which the count reaches the limit.
module bus_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins over enable, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 16'd0;
        end else if (enable) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The current cycle is the limit-th enabled cycle; widened to avoid wrap.
    assign expired = enable && (({1'b0, count_q} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// accesses. Data wins when both request in IDLE. Address/data/write-enable are
// latched at grant and held for the whole access; the owner's ack pulses
// during the single RESP cycle, which never evaluates requests.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that stay busy for
// TIMEOUT_CYCLES cycles (ack with ABORT_DATA and a sticky bus_err).
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        bus_err
);

    arb_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        abort_s;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic timer_clear_s;
    logic timer_en_s;
    logic bus_err_q, bus_err_d;

    assign timer_clear_s = (state_q == IDLE) && (if_req || d_req);
    assign timer_en_s    = (state_q == BUSY_IF) || (state_q == BUSY_D);

    bus_timer u_bus_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .limit   (TIMEOUT_LIMIT),
        .expired (abort_s)
    );

    // An abort only counts when memory did not answer in the same cycle.
    assign bus_err_d = bus_err_q || (timer_en_s && abort_s && !mem_ack);

    // Sticky bus error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign abort_s = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    state_d    = RESP;
                end else if (abort_s) begin
                    if_rdata_d = ABORT_DATA;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    state_d    = RESP;
                end else begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (mem_ack || abort_s) begin
                    // Stores complete without touching the load data register.
                    if (mem_we_q) begin
                        d_rdata_d = d_rdata_q;
                    end else if (mem_ack) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = ABORT_DATA;
                    end
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = BUSY_D;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;

    // Pipeline freeze: an outstanding request that is not completing this cycle.
    assign stall = (if_req || d_req) && !(if_ack_q || d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized accesses,
// checked against a transaction-level reference (expected read words, latched
// request fields and latency derived from the memory latency).
module tb_mem_arbiter;

    localparam int TO_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] exp_if_rdata = 32'd0;
    logic [31:0] exp_d_rdata  = 32'd0;

    // memory model controls
    int mem_lat   = 1;
    bit mem_never = 1'b0;
    int mem_cnt   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h00400000) return 32'h8C080004;
        return {a[15:0], a[31:16]} ^ 32'h5A5A3C3C;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: acks on the mem_lat-th mem_req cycle; random stray acks while idle.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                mem_cnt++;
                if (!mem_never && mem_cnt == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_cnt   = 0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // Wait for the owner's ack; while busy, check stall and latched fields and
    // scramble the owner's inputs.
    task automatic wait_ack(input bit is_d, input logic [31:0] ea, input bit ewe,
                            input logic [31:0] ewd, input int budget, output int k);
        bit got;
        got = 1'b0;
        k   = 0;
        while (!got && k < budget) begin
            @(negedge clk);
            k++;
            if ((is_d ? d_ack : if_ack) === 1'b1) begin
                got = 1'b1;
            end else begin
                check32("stall_wait", {31'd0, stall}, 32'd1);
                check32("other_ack_wait", {31'd0, (is_d ? if_ack : d_ack)}, 32'd0);
                if (mem_req === 1'b1) begin
                    check32("mem_addr_hold", mem_addr, ea);
                    check32("mem_we_hold", {31'd0, mem_we}, {31'd0, ewe});
                    if (is_d) check32("mem_wdata_hold", mem_wdata, ewd);
                    if (is_d) begin
                        d_addr  = $urandom;
                        d_wdata = $urandom;
                        d_we    = 1'($urandom_range(0, 1));
                    end else begin
                        if_addr = $urandom;
                    end
                end
            end
        end
        n_assert++;
        assert (got)
        else begin
            n_fail++;
            $error("FAIL ack_wait: observed no ack in %0d cycles expected ack", budget);
        end
    endtask

    // One complete access through the arbiter, checked against the model.
    task automatic do_access(input bit is_d, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input int lat, input bit hold);
        int k;
        mem_lat   = lat;
        mem_never = 1'b0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        #1 check32("stall_req", {31'd0, stall}, 32'd1);
        wait_ack(is_d, a, is_d ? we : 1'b0, wd, 50, k);
        check32("latency", k + 1, lat + 2);
        if (is_d) begin
            if (!we) exp_d_rdata = mem_word(a);
        end else begin
            exp_if_rdata = mem_word(a);
        end
        check32("if_rdata", if_rdata, exp_if_rdata);
        check32("d_rdata", d_rdata, exp_d_rdata);
        check32("other_ack", {31'd0, (is_d ? if_ack : d_ack)}, 32'd0);
        check32("mem_req_resp", {31'd0, mem_req}, 32'd0);
        check32("stall_ack", {31'd0, stall}, 32'd0);
        if (!hold) begin
            if (is_d) d_req = 1'b0; else if_req = 1'b0;
        end
        @(negedge clk);
        check32("ack_pulse", {30'd0, if_ack, d_ack}, 32'd0);
        check32("no_regrant", {31'd0, mem_req}, 32'd0);
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    initial begin
        int k;
        // reset state
        repeat (2) @(negedge clk);
        check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check32("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check32("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check32("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_if_rdata", if_rdata, 32'd0);
        check32("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single fetch, 1-cycle memory
        do_access(1'b0, 1'b0, 32'h00400000, 32'd0, 1, 1'b0);
        check32("fetch_word", if_rdata, 32'h8C080004);

        // simultaneous requests: data first, then fetch
        mem_lat = 2; mem_never = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010000; d_wdata = 32'h0BADF00D;
        if_req = 1'b1; if_addr = 32'h00400004;
        wait_ack(1'b1, 32'h10010000, 1'b0, 32'h0BADF00D, 50, k);
        exp_d_rdata = mem_word(32'h10010000);
        check32("sim_d_rdata", d_rdata, exp_d_rdata);
        check32("sim_if_ack_low", {31'd0, if_ack}, 32'd0);
        d_req = 1'b0;
        if_addr = 32'h00400004;
        wait_ack(1'b0, 32'h00400004, 1'b0, 32'd0, 50, k);
        exp_if_rdata = mem_word(32'h00400004);
        check32("sim_if_rdata", if_rdata, exp_if_rdata);
        if_req = 1'b0;
        @(negedge clk);

        // load then store with 4-cycle latency (store leaves d_rdata alone)
        do_access(1'b1, 1'b0, 32'h10010020, 32'd0, 2, 1'b0);
        do_access(1'b1, 1'b1, 32'h10010040, 32'h12345678, 4, 1'b0);

        // request left high through the ack cycle is not re-granted
        do_access(1'b0, 1'b0, 32'h00400010, 32'd0, 3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom, $urandom_range(1, 5), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset in BUSY_D cycle 2
        mem_never = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010080;
        @(negedge clk);
        check32("busy_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0;
        #1;
        check32("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check32("arst_mem_addr", mem_addr, 32'd0);
        check32("arst_mem_wdata", mem_wdata, 32'd0);
        check32("arst_rdata", if_rdata | d_rdata, 32'd0);
        exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
        @(negedge clk);
        reset = 1'b1; mem_never = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check32("post_rst_quiet", {30'd0, d_ack, mem_req}, 32'd0);
        end
        do_access(1'b0, 1'b0, 32'h00400000, 32'd0, 1, 1'b0);

        // memory that never answers
        mem_never = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010100; d_wdata = 32'd0;
`ifdef MEM_TIMEOUT_EN
        wait_ack(1'b1, 32'h10010100, 1'b0, 32'd0, 40, k);
        check32("to_cycles", k, TO_CYCLES + 1);
        check32("to_rdata", d_rdata, 32'hDEADBEEF);
        check32("to_bus_err", {31'd0, bus_err}, 32'd1);
        exp_d_rdata = 32'hDEADBEEF;
        d_req = 1'b0;
        @(negedge clk);
        do_access(1'b0, 1'b0, 32'h00400020, 32'd0, 2, 1'b0);
        check32("to_sticky", {31'd0, bus_err}, 32'd1);
`else
        @(negedge clk);
        repeat (120) begin
            @(negedge clk);
            check32("hang_state", {29'd0, d_ack, bus_err, mem_req}, 32'd1);
        end
        d_req = 1'b0;
`endif
        reset = 1'b0;
        #1 check32("final_rst_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_never = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
